// File: rtl/cpu_pkg.sv
// Shared constants and types for the tp1 core and its data-side peripherals.
// Holds the data bus memory map, the UART status bit positions and the UART transmitter states.
package cpu_pkg;

    localparam logic [7:0] RAM_TOP        = 8'hEF;
    localparam logic [7:0] ADDR_LEDS      = 8'hF0;
    localparam logic [7:0] ADDR_SW        = 8'hF1;
    localparam logic [7:0] ADDR_UART_DATA = 8'hF2;
    localparam logic [7:0] ADDR_UART_STAT = 8'hF3;
    localparam logic [7:0] ADDR_TIMER     = 8'hF4;

    localparam int RAM_DEPTH = 240;

    localparam int UART_STAT_BUSY    = 0;
    localparam int UART_STAT_OVERRUN = 1;

    typedef enum logic [1:0] {
        UartState_IDLE,
        UartState_START,
        UartState_DATA,
        UartState_STOP
    } UartState;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first; every state and data bit lasts BAUD_DIV clocks.
// The start bit goes onto the line at the same edge that accepts _iStart.
//  state | meaning
//  IDLE  | line high, waiting for _iStart
//  START | start bit (0) on the line
//  DATA  | shifting out the 8 data bits
//  STOP  | stop bit (1); leaving it returns to IDLE and drops busy
module uart_tx
    import cpu_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       _iClk,
    input  logic       _iReset,
    input  logic       _iStart,
    input  logic [7:0] _iData,
    output logic       _oBusy,
    output logic       _oTx
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    UartState state, stateNext;
    logic [CNT_W-1:0] baudCnt, baudCntNext;
    logic [2:0] bitCnt, bitCntNext;
    logic [7:0] shiftReg, shiftRegNext;
    logic tx, txNext;

    always_ff @(posedge _iClk or negedge _iReset) begin
        if (!_iReset) begin
            state    <= UartState_IDLE;
            baudCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudCntNext;
            bitCnt   <= bitCntNext;
            shiftReg <= shiftRegNext;
            tx       <= txNext;
        end
    end

    always_comb begin
        stateNext    = state;
        baudCntNext  = baudCnt;
        bitCntNext   = bitCnt;
        shiftRegNext = shiftReg;
        txNext       = tx;
        case (state)
            UartState_IDLE: begin
                if (_iStart) begin
                    stateNext    = UartState_START;
                    baudCntNext  = BAUD_LAST;
                    shiftRegNext = _iData;
                    txNext       = 1'b0;
                end
            end
            UartState_START: begin
                if (baudCnt == '0) begin
                    stateNext   = UartState_DATA;
                    baudCntNext = BAUD_LAST;
                    bitCntNext  = 3'd7;
                    txNext      = shiftReg[0];
                end else begin
                    baudCntNext = baudCnt - CNT_W'(1);
                end
            end
            UartState_DATA: begin
                if (baudCnt == '0) begin
                    baudCntNext = BAUD_LAST;
                    if (bitCnt == 3'd0) begin
                        stateNext = UartState_STOP;
                        txNext    = 1'b1;
                    end else begin
                        bitCntNext   = bitCnt - 3'd1;
                        shiftRegNext = {1'b0, shiftReg[7:1]};
                        txNext       = shiftReg[1];
                    end
                end else begin
                    baudCntNext = baudCnt - CNT_W'(1);
                end
            end
            UartState_STOP: begin
                if (baudCnt == '0) begin
                    stateNext = UartState_IDLE;
                end else begin
                    baudCntNext = baudCnt - CNT_W'(1);
                end
            end
            default: begin
                stateNext = UartState_IDLE;
                txNext    = 1'b1;
            end
        endcase
    end

    assign _oBusy = (state != UartState_IDLE);
    assign _oTx   = tx;

endmodule

// File: rtl/data_bus.sv
// Data-side slave of the tp1 core: RAM plus memory-mapped LEDs, switches, UART and timer.
// Read data is a combinational function of the address; writes land on the clock edge.
module data_bus
    import cpu_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int TIMER_DIV = 50_000
) (
    input  logic       _iClk,
    input  logic       _iReset,
    input  logic [7:0] _iAddr,
    input  logic [7:0] _iWData,
    input  logic       _iWrite,
    output logic [7:0] _oRData,
    input  logic [7:0] _iSwitches,
    output logic [7:0] _oLeds,
    output logic       _oUartTx
);

    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int PRE_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TIMER_DIV - 1);

    logic [7:0] ram [0:RAM_DEPTH-1];
    logic [7:0] leds;
    logic [7:0] swMeta;
    logic [7:0] swSync;
    logic [7:0] uartData;
    logic [7:0] uartStat;
    logic [7:0] timer;
    logic [PRE_W-1:0] prescaler;
    logic overrun;
    logic uartBusy;
    logic uartStart;
    logic overrunSet;
    logic overrunClr;
    logic wrRam, wrLeds, wrUartData, wrUartStat, wrTimer;

    assign wrRam      = _iWrite && (_iAddr <= RAM_TOP);
    assign wrLeds     = _iWrite && (_iAddr == ADDR_LEDS);
    assign wrUartData = _iWrite && (_iAddr == ADDR_UART_DATA);
    assign wrUartStat = _iWrite && (_iAddr == ADDR_UART_STAT);
    assign wrTimer    = _iWrite && (_iAddr == ADDR_TIMER);

    // A data write while a frame is in flight is dropped and only flags overrun.
    assign uartStart  = wrUartData && !uartBusy;
    assign overrunSet = wrUartData && uartBusy;
    assign overrunClr = wrUartStat && _iWData[UART_STAT_OVERRUN];

    always_ff @(posedge _iClk) begin
        if (wrRam) begin
            ram[_iAddr] <= _iWData;
        end
    end

    always_ff @(posedge _iClk or negedge _iReset) begin
        if (!_iReset) begin
            leds     <= '0;
            swMeta   <= '0;
            swSync   <= '0;
            uartData <= '0;
            overrun  <= 1'b0;
        end else begin
            swMeta <= _iSwitches;
            swSync <= swMeta;
            if (wrLeds) begin
                leds <= _iWData;
            end
            if (uartStart) begin
                uartData <= _iWData;
            end
            if (overrunSet) begin
                overrun <= 1'b1;
            end else if (overrunClr) begin
                overrun <= 1'b0;
            end
        end
    end

    // Software load wins over the prescaler wrap and restarts the count.
    always_ff @(posedge _iClk or negedge _iReset) begin
        if (!_iReset) begin
            timer     <= '0;
            prescaler <= '0;
        end else if (wrTimer) begin
            timer     <= _iWData;
            prescaler <= '0;
        end else if (prescaler == PRE_LAST) begin
            timer     <= timer + 8'd1;
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    uart_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) uUartTx (
        ._iClk  (_iClk),
        ._iReset(_iReset),
        ._iStart(uartStart),
        ._iData (_iWData),
        ._oBusy (uartBusy),
        ._oTx   (_oUartTx)
    );

    always_comb begin
        uartStat = '0;
        uartStat[UART_STAT_BUSY]    = uartBusy;
        uartStat[UART_STAT_OVERRUN] = overrun;
    end

    always_comb begin
        _oRData = '0;
        if (_iAddr <= RAM_TOP) begin
            _oRData = ram[_iAddr];
        end else begin
            case (_iAddr)
                ADDR_LEDS:      _oRData = leds;
                ADDR_SW:        _oRData = swSync;
                ADDR_UART_DATA: _oRData = uartData;
                ADDR_UART_STAT: _oRData = uartStat;
                ADDR_TIMER:     _oRData = timer;
                default:        _oRData = '0;
            endcase
        end
    end

    assign _oLeds = leds;

endmodule

// File: tb/tb_data_bus.sv
// Directed bench for data_bus with BAUD_DIV=4 and TIMER_DIV=3.
// Inputs change away from the rising edge; outputs are sampled 1-2 ns after it or mid-cycle.
module tb_data_bus;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       write = 1'b0;
    logic [7:0] rdata;
    logic [7:0] switches = '0;
    logic [7:0] leds;
    logic       tx;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    data_bus #(
        .CLK_HZ(4),
        .BAUD(1),
        .TIMER_DIV(3)
    ) dut (
        ._iClk     (clk),
        ._iReset   (rst),
        ._iAddr    (addr),
        ._iWData   (wdata),
        ._iWrite   (write),
        ._oRData   (rdata),
        ._iSwitches(switches),
        ._oLeds    (leds),
        ._oUartTx  (tx)
    );

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; write = 1'b1;
        @(posedge clk);
        #1 write = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #12;
        addr = 8'hF0; #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_leds_rd got=%h exp=00", rdata); end
        total++; if (leds !== 8'h00) begin bad++; $display("FAIL reset_leds got=%h exp=00", leds); end
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
        addr = 8'hF2; #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_uart_data got=%h exp=00", rdata); end
        addr = 8'hF3; #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_uart_stat got=%h exp=00", rdata); end
        addr = 8'hF4; #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_timer got=%h exp=00", rdata); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_ram;
        bus_write(8'h10, 8'h5A);
        addr = 8'h10; #1;
        total++; if (rdata !== 8'h5A) begin bad++; $display("FAIL ram_10 got=%h exp=5a", rdata); end
        bus_write(8'hEF, 8'h01);
        addr = 8'hEF; #1;
        total++; if (rdata !== 8'h01) begin bad++; $display("FAIL ram_ef got=%h exp=01", rdata); end
        bus_write(8'hF8, 8'h77);
        addr = 8'hF8; #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL unmapped_f8 got=%h exp=00", rdata); end
        @(negedge clk);
        addr = 8'h10; wdata = 8'hC3; write = 1'b1; #1;
        total++; if (rdata !== 8'h5A) begin bad++; $display("FAIL ram_rdw_old got=%h exp=5a", rdata); end
        @(posedge clk);
        #1 write = 1'b0; #1;
        total++; if (rdata !== 8'hC3) begin bad++; $display("FAIL ram_rdw_new got=%h exp=c3", rdata); end
    endtask

    task automatic test_leds;
        @(negedge clk);
        addr = 8'hF0; wdata = 8'hA5; write = 1'b1; #1;
        total++; if (leds !== 8'h00) begin bad++; $display("FAIL leds_before_edge got=%h exp=00", leds); end
        @(posedge clk);
        #1 write = 1'b0; #1;
        total++; if (leds !== 8'hA5) begin bad++; $display("FAIL leds_after_edge got=%h exp=a5", leds); end
        total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL leds_rd got=%h exp=a5", rdata); end
        #1 rst = 1'b0; #1;
        total++; if (leds !== 8'h00) begin bad++; $display("FAIL leds_async_reset got=%h exp=00", leds); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_switches;
        @(negedge clk);
        switches = 8'h3C; addr = 8'hF1; #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL sw_edge0 got=%h exp=00", rdata); end
        @(posedge clk); #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL sw_edge1 got=%h exp=00", rdata); end
        @(posedge clk); #1;
        total++; if (rdata !== 8'h3C) begin bad++; $display("FAIL sw_edge2 got=%h exp=3c", rdata); end
    endtask

    // Sends one frame and checks the line every cycle; optionally writes wrVal to 0xF2 in cycle wrAt.
    task automatic uart_frame(input logic [7:0] data, input int wrAt, input logic [7:0] wrVal,
                              input logic [7:0] exp38, input logic [7:0] expEnd);
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        @(negedge clk);
        addr = 8'hF2; wdata = data; write = 1'b1;
        @(posedge clk);
        #1 write = 1'b0; addr = 8'hF3;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                if (write) begin write = 1'b0; addr = 8'hF3; end
            end
            #1;
            total++; if (tx !== frame[k/4]) begin bad++; $display("FAIL uart_tx_bit k=%0d got=%b exp=%b", k, tx, frame[k/4]); end
            total++; if (rdata[0] !== 1'b1) begin bad++; $display("FAIL uart_busy k=%0d got=%b exp=1", k, rdata[0]); end
            if (k == 38) begin
                total++; if (rdata !== exp38) begin bad++; $display("FAIL uart_stat_late got=%h exp=%h", rdata, exp38); end
            end
            if (k == wrAt) begin addr = 8'hF2; wdata = wrVal; write = 1'b1; end
        end
        @(posedge clk);
        #1 write = 1'b0; addr = 8'hF3; #1;
        total++; if (rdata !== expEnd) begin bad++; $display("FAIL uart_stat_end got=%h exp=%h", rdata, expEnd); end
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL uart_tx_idle got=%b exp=1", tx); end
        addr = 8'hF2; #1;
        total++; if (rdata !== data) begin bad++; $display("FAIL uart_data_rd got=%h exp=%h", rdata, data); end
    endtask

    task automatic test_uart;
        uart_frame(8'h41, -1, 8'h00, 8'h01, 8'h00);
    endtask

    task automatic test_overrun;
        uart_frame(8'h41, 10, 8'h42, 8'h03, 8'h02);
        bus_write(8'hF3, 8'h01);
        addr = 8'hF3; #1;
        total++; if (rdata !== 8'h02) begin bad++; $display("FAIL ovr_keep got=%h exp=02", rdata); end
        bus_write(8'hF3, 8'h02);
        addr = 8'hF3; #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL ovr_clear got=%h exp=00", rdata); end
        uart_frame(8'h55, 39, 8'h99, 8'h01, 8'h02);
        bus_write(8'hF3, 8'h02);
        addr = 8'hF3; #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL ovr_clear2 got=%h exp=00", rdata); end
    endtask

    task automatic test_uart_reset;
        @(negedge clk);
        addr = 8'hF2; wdata = 8'h00; write = 1'b1;
        @(posedge clk);
        #1 write = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL uart_mid_frame got=%b exp=0", tx); end
        rst = 1'b0; #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL uart_abort_tx got=%b exp=1", tx); end
        addr = 8'hF3; #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL uart_abort_stat got=%h exp=00", rdata); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_timer;
        logic [7:0] exp;
        bus_write(8'hF4, 8'h00);
        addr = 8'hF4; #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL timer_load got=%h exp=00", rdata); end
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #2;
            exp = 8'(i / 3);
            total++; if (rdata !== exp) begin bad++; $display("FAIL timer_step i=%0d got=%h exp=%h", i, rdata, exp); end
        end
        bus_write(8'hF4, 8'hFE);
        addr = 8'hF4;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #2;
            exp = (i < 3) ? 8'hFE : ((i < 6) ? 8'hFF : 8'h00);
            total++; if (rdata !== exp) begin bad++; $display("FAIL timer_wrap i=%0d got=%h exp=%h", i, rdata, exp); end
        end
        bus_write(8'hF4, 8'h10);
        addr = 8'hF4;
        repeat (2) @(posedge clk);
        #2;
        total++; if (rdata !== 8'h10) begin bad++; $display("FAIL timer_pre_wrap got=%h exp=10", rdata); end
        wdata = 8'h80; write = 1'b1;
        @(posedge clk);
        #1 write = 1'b0; #1;
        total++; if (rdata !== 8'h80) begin bad++; $display("FAIL timer_load_wins got=%h exp=80", rdata); end
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #2;
            exp = (i < 3) ? 8'h80 : 8'h81;
            total++; if (rdata !== exp) begin bad++; $display("FAIL timer_after_load i=%0d got=%h exp=%h", i, rdata, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_leds();
        test_switches();
        test_uart();
        test_overrun();
        test_uart_reset();
        test_timer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
